// File: rtl/tds_check_pkg.sv
// tds_check_pkg: state encoding and counter widths shared by tds_frame_checker
// and its submodule.
package tds_check_pkg;

  // Link state encoding. The numeric values are visible on the state output.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    SYNC   = 2'd2,
    LINKED = 2'd3
  } tds_state_e;

  // Width of the syn_cnt run counter. It must hold SYNC_CNT up to 1023.
  localparam int SYN_W = 10;

  // Width of the word_cnt statistic.
  localparam int WORD_W = 32;

  // Width of the consecutive-bad-word run. It must hold LOSS_THR up to 255.
  localparam int BAD_W = 8;

endpackage : tds_check_pkg

// File: rtl/tds_frame_checker_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones. A synchronous clear has
// priority over a coincident increment. The counter also resets on srst_i.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/tds_frame_checker.sv
// tds_frame_checker: checks the words from one deserializer stream.
// Each valid word must carry a fixed header and an incrementing sequence
// number. The block hunts for a header, then collects a run of good words
// before it declares lock. It drops lock after a run of consecutive bad words.
// Saturating error and word statistics are kept while the link is up.
// Optional build macro TDS_FRAME_CHECKER_ERR_LOG_EN adds a capture of the
// first bad word seen while linked.
module tds_frame_checker
  import tds_check_pkg::*;
#(
  parameter int               DATA_W   = 30,
  parameter int               HDR_W    = 4,
  parameter logic [HDR_W-1:0] HDR_VAL  = 4'hA,
  parameter int               CNT_W    = 10,
  parameter int               SYNC_CNT = 16,
  parameter int               LOSS_THR = 4,
  parameter int               ERR_W    = 16
) (
  input  logic              clk160,
  input  logic              reset_160M,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              rx_aligned,
  input  logic              clear_cnt,
  output logic              linked,
  output logic [1:0]        state,
  output logic [SYN_W-1:0]  syn_cnt,
  output logic [ERR_W-1:0]  err_cnt,
`ifdef TDS_FRAME_CHECKER_ERR_LOG_EN
  output logic [DATA_W-1:0] first_err_data,
  output logic [CNT_W-1:0]  first_err_exp,
  output logic              first_err_valid,
`endif
  output logic [WORD_W-1:0] word_cnt
);

  // Thresholds brought to the widths of the registers they are compared with.
  localparam logic [SYN_W-1:0] SYNC_TGT = SYN_W'(SYNC_CNT);
  localparam logic [BAD_W-1:0] LOSS_TGT = BAD_W'(LOSS_THR);

  tds_state_e       state_q;
  logic [CNT_W-1:0] exp_seq_q;
  logic [SYN_W-1:0] syn_cnt_q;
  logic [BAD_W-1:0] bad_run_q;
  logic             linked_q;

  logic [HDR_W-1:0] hdr_field;
  logic [CNT_W-1:0] seq_field;
  logic             hdr_ok;
  logic             word_good;
  logic [SYN_W-1:0] syn_cnt_d;
  logic [BAD_W-1:0] bad_run_d;
  logic             word_ev;
  logic             err_ev;

  assign hdr_field = data_in[DATA_W-1 -: HDR_W];
  assign seq_field = data_in[CNT_W-1:0];
  assign hdr_ok    = (hdr_field == HDR_VAL);
  assign word_good = hdr_ok && (seq_field == exp_seq_q);
  assign syn_cnt_d = syn_cnt_q + SYN_W'(1);
  assign bad_run_d = bad_run_q + BAD_W'(1);

  // The bits between the header and the sequence field carry payload
  // that this checker does not inspect.
  generate
    if (DATA_W > HDR_W + CNT_W) begin : g_mid
      logic unused_mid;
      assign unused_mid = ^data_in[DATA_W-HDR_W-1:CNT_W];
    end
  endgenerate

  // Statistic events. These count only while linked and aligned, because a
  // dropped alignment overrides any data event in the same cycle.
  assign word_ev = rx_aligned && data_valid && (state_q == LINKED);
  assign err_ev  = word_ev && !word_good;

  // Link state machine. Its outputs and the expected sequence are registered
  // together. Alignment loss outranks every data event.
  always_ff @(posedge clk160) begin
    if (reset_160M) begin
      state_q   <= IDLE;
      exp_seq_q <= '0;
      syn_cnt_q <= '0;
      bad_run_q <= '0;
      linked_q  <= 1'b0;
    end else if (!rx_aligned) begin
      state_q   <= IDLE;
      syn_cnt_q <= '0;
      bad_run_q <= '0;
      linked_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= HUNT;
        end
        HUNT: begin
          if (data_valid) begin
            // Adopt the sequence of whatever arrives; only the header gates progress.
            exp_seq_q <= seq_field + CNT_W'(1);
            if (hdr_ok) begin
              if (SYNC_CNT == 1) begin
                state_q   <= LINKED;
                syn_cnt_q <= SYNC_TGT;
                linked_q  <= 1'b1;
              end else begin
                state_q   <= SYNC;
                syn_cnt_q <= SYN_W'(1);
              end
            end
          end
        end
        SYNC: begin
          if (data_valid) begin
            exp_seq_q <= exp_seq_q + CNT_W'(1);
            if (word_good) begin
              syn_cnt_q <= syn_cnt_d;
              if (syn_cnt_d == SYNC_TGT) begin
                state_q  <= LINKED;
                linked_q <= 1'b1;
              end
            end else begin
              state_q   <= HUNT;
              syn_cnt_q <= '0;
            end
          end
        end
        LINKED: begin
          if (data_valid) begin
            // Always step the expectation, so a single corrupted word costs
            // one error and a slipped stream keeps failing until lock drops.
            exp_seq_q <= exp_seq_q + CNT_W'(1);
            if (word_good) begin
              bad_run_q <= '0;
            end else if (bad_run_d == LOSS_TGT) begin
              state_q   <= HUNT;
              bad_run_q <= '0;
              syn_cnt_q <= '0;
              linked_q  <= 1'b0;
            end else begin
              bad_run_q <= bad_run_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign linked  = linked_q;
  assign state   = state_q;
  assign syn_cnt = syn_cnt_q;

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk_i  (clk160),
    .srst_i (reset_160M),
    .inc_i  (err_ev),
    .clr_i  (clear_cnt),
    .cnt_o  (err_cnt)
  );

  sat_counter #(
    .WIDTH (WORD_W)
  ) u_word_cnt (
    .clk_i  (clk160),
    .srst_i (reset_160M),
    .inc_i  (word_ev),
    .clr_i  (clear_cnt),
    .cnt_o  (word_cnt)
  );

`ifdef TDS_FRAME_CHECKER_ERR_LOG_EN
  logic [DATA_W-1:0] first_err_data_q;
  logic [CNT_W-1:0]  first_err_exp_q;
  logic              first_err_valid_q;

  // Capture the first bad linked word and its expected sequence; hold until cleared.
  always_ff @(posedge clk160) begin
    if (reset_160M || clear_cnt) begin
      first_err_data_q  <= '0;
      first_err_exp_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else if (err_ev && !first_err_valid_q) begin
      first_err_data_q  <= data_in;
      first_err_exp_q   <= exp_seq_q;
      first_err_valid_q <= 1'b1;
    end
  end

  assign first_err_data  = first_err_data_q;
  assign first_err_exp   = first_err_exp_q;
  assign first_err_valid = first_err_valid_q;
`endif

endmodule : tds_frame_checker

// File: tb/tb_tds_frame_checker.sv
// Scoreboard bench for tds_frame_checker. The stimulus task issues one cycle
// of inputs and pushes the output state the reference model predicts for the
// following edge. A monitor pops one entry after each edge and compares it.
// The error counter is 4 bits wide here, so saturation is reachable.
module tb_tds_frame_checker;

  localparam int DATA_W   = 30;
  localparam int HDR_W    = 4;
  localparam int HDR_VAL  = 10;
  localparam int CNT_W    = 10;
  localparam int SYNC_CNT = 16;
  localparam int LOSS_THR = 4;
  localparam int ERR_W    = 4;
  localparam int SEQ_MOD  = 1 << CNT_W;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  typedef struct packed {
    logic              linked;
    logic [1:0]        st;
    logic [9:0]        syn;
    logic [ERR_W-1:0]  err;
    logic [31:0]       words;
    logic              lv;
    logic [DATA_W-1:0] ld;
    logic [CNT_W-1:0]  le;
  } exp_t;

  logic              clk160 = 1'b0;
  logic              reset_160M = 1'b1;
  logic [DATA_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              rx_aligned = 1'b0;
  logic              clear_cnt = 1'b0;
  logic              linked;
  logic [1:0]        state;
  logic [9:0]        syn_cnt;
  logic [ERR_W-1:0]  err_cnt;
  logic [31:0]       word_cnt;
`ifdef TDS_FRAME_CHECKER_ERR_LOG_EN
  logic [DATA_W-1:0] first_err_data;
  logic [CNT_W-1:0]  first_err_exp;
  logic              first_err_valid;
`endif

  always #5 clk160 = ~clk160;

  tds_frame_checker #(
    .DATA_W   (DATA_W),
    .HDR_W    (HDR_W),
    .HDR_VAL  (4'hA),
    .CNT_W    (CNT_W),
    .SYNC_CNT (SYNC_CNT),
    .LOSS_THR (LOSS_THR),
    .ERR_W    (ERR_W)
  ) dut (
    .clk160          (clk160),
    .reset_160M      (reset_160M),
    .data_in         (data_in),
    .data_valid      (data_valid),
    .rx_aligned      (rx_aligned),
    .clear_cnt       (clear_cnt),
    .linked          (linked),
    .state           (state),
    .syn_cnt         (syn_cnt),
    .err_cnt         (err_cnt),
`ifdef TDS_FRAME_CHECKER_ERR_LOG_EN
    .first_err_data  (first_err_data),
    .first_err_exp   (first_err_exp),
    .first_err_valid (first_err_valid),
`endif
    .word_cnt        (word_cnt)
  );

  // Reference model state. mode follows the published encoding:
  // 0 idle, 1 hunting, 2 synchronising, 3 linked.
  int          m_mode, m_exp, m_run, m_bad, m_err;
  longint      m_words;
  bit          m_lv;
  bit [DATA_W-1:0] m_ld;
  int          m_le;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_no = 0;
  int   tx = 0;

  function automatic void model_step(input bit rst, input bit al, input bit v,
                                     input bit clr, input bit [DATA_W-1:0] d,
                                     output exp_t e);
    int  hdr;
    int  sq;
    bit  good;
    hdr = int'(d[DATA_W-1 -: HDR_W]);
    sq  = int'(d[CNT_W-1:0]);
    if (rst) begin
      m_mode = 0; m_exp = 0; m_run = 0; m_bad = 0;
      m_err = 0; m_words = 0; m_lv = 0; m_ld = '0; m_le = 0;
    end else begin
      good = (hdr == HDR_VAL) && (sq == m_exp);
      // Statistics: a clear beats anything counted in the same cycle.
      if (clr) begin
        m_err = 0; m_words = 0; m_lv = 0; m_ld = '0; m_le = 0;
      end else if (al && v && m_mode == 3) begin
        if (m_words < 64'hFFFF_FFFF) m_words = m_words + 1;
        if (!good) begin
          if (m_err < ERR_MAX) m_err = m_err + 1;
          if (!m_lv) begin
            m_lv = 1; m_ld = d; m_le = m_exp;
          end
        end
      end
      // Link tracking.
      if (!al) begin
        m_mode = 0; m_run = 0; m_bad = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (v) begin
        if (m_mode == 1) begin
          m_exp = (sq + 1) % SEQ_MOD;
          if (hdr == HDR_VAL) begin
            m_run  = 1;
            m_mode = (m_run >= SYNC_CNT) ? 3 : 2;
          end
        end else begin
          m_exp = (m_exp + 1) % SEQ_MOD;
          if (m_mode == 2) begin
            if (good) begin
              m_run = m_run + 1;
              if (m_run == SYNC_CNT) m_mode = 3;
            end else begin
              m_mode = 1; m_run = 0;
            end
          end else if (good) begin
            m_bad = 0;
          end else begin
            m_bad = m_bad + 1;
            if (m_bad == LOSS_THR) begin
              m_mode = 1; m_bad = 0; m_run = 0;
            end
          end
        end
      end
    end
    e.linked = (m_mode == 3);
    e.st     = 2'(m_mode);
    e.syn    = 10'(m_run);
    e.err    = ERR_W'(m_err);
    e.words  = 32'(m_words);
    e.lv     = m_lv;
    e.ld     = m_ld;
    e.le     = CNT_W'(m_le);
  endfunction

  function automatic bit [DATA_W-1:0] mkword(input int hdr, input int sq);
    bit [DATA_W-1:0] w;
    w = DATA_W'($urandom);
    w[DATA_W-1 -: HDR_W] = HDR_W'(hdr);
    w[CNT_W-1:0] = CNT_W'(sq & (SEQ_MOD - 1));
    return w;
  endfunction

  // One clock of stimulus plus the matching scoreboard entry.
  task automatic cyc(input bit rst, input bit al, input bit v, input bit clr,
                     input bit [DATA_W-1:0] d);
    exp_t e;
    @(negedge clk160);
    reset_160M = rst;
    rx_aligned = al;
    data_valid = v;
    clear_cnt  = clr;
    data_in    = d;
    model_step(rst, al, v, clr, d, e);
    sb_q.push_back(e);
  endtask

  // Send the next in-order good word.
  task automatic good_word();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, mkword(HDR_VAL, tx));
    tx++;
  endtask

  // Monitor: compare the DUT against the oldest prediction after every edge.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk160);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a.linked = linked;
        a.st     = state;
        a.syn    = syn_cnt;
        a.err    = err_cnt;
        a.words  = word_cnt;
`ifdef TDS_FRAME_CHECKER_ERR_LOG_EN
        a.lv = first_err_valid;
        a.ld = first_err_data;
        a.le = first_err_exp;
`else
        a.lv = 1'b0; a.ld = '0; a.le = '0;
        e.lv = 1'b0; e.ld = '0; e.le = '0;
`endif
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs cyc%0d: got linked=%0d state=%0d syn=%0d err=%0d words=%0d logv=%0d logd=%h loge=%0d, want linked=%0d state=%0d syn=%0d err=%0d words=%0d logv=%0d logd=%h loge=%0d",
                   cyc_no, a.linked, a.st, a.syn, a.err, a.words, a.lv, a.ld, a.le,
                   e.linked, e.st, e.syn, e.err, e.words, e.lv, e.ld, e.le);
        end else begin
          $display("[TB] cyc%0d ok state=%0d syn=%0d err=%0d words=%0d",
                   cyc_no, a.st, a.syn, a.err, a.words);
        end
        cyc_no++;
      end
    end
  end

  initial begin
    bit [DATA_W-1:0] d;
    bit rst, al, v, clr;
    int r, r2, h;

    // Reset with random other inputs, then idle unaligned.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), DATA_W'($urandom));
    cyc(1'b0, 1'b0, 1'b1, 1'b0, mkword(HDR_VAL, 0));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Clean lock on an in-order stream.
    for (int i = 0; i < 40; i++) good_word();

    // Clear counters, then a known first bad word.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, mkword(HDR_VAL, tx)); tx++;
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 30'h2A00_0123); tx++;
    for (int i = 0; i < 6; i++) good_word();

    // Single sequence corruption, then a header corruption.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, mkword(HDR_VAL, tx + 517)); tx++;
    for (int i = 0; i < 6; i++) good_word();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, mkword(3, tx)); tx++;
    for (int i = 0; i < 6; i++) good_word();

    // Dropped word: persistent errors, lock loss, relock.
    tx++;
    for (int i = 0; i < 30; i++) good_word();

    // Interleaved errors drive the error counter into saturation.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0, mkword(HDR_VAL, tx + 300)); tx++;
      good_word();
    end
    // Clear coinciding with an error.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, mkword(HDR_VAL, tx + 9)); tx++;
    good_word();

    // Alignment loss while linked, then again mid-synchronisation.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, mkword(HDR_VAL, tx)); tx++;
    for (int i = 0; i < 6; i++) good_word();
    cyc(1'b0, 1'b0, 1'b1, 1'b0, mkword(HDR_VAL, tx)); tx++;
    for (int i = 0; i < 25; i++) good_word();

    // Long in-order stream with gaps, crossing the sequence wrap.
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 7) != 0);
      cyc(1'b0, 1'b1, v, 1'b0, mkword(HDR_VAL, tx));
      if (v) tx++;
    end

    // Random mix of corruption, slips, clears, alignment loss and reset.
    for (int i = 0; i < 3000; i++) begin
      r   = $urandom_range(0, 999);
      rst = (r == 0);
      al  = !(r >= 1 && r <= 3);
      clr = (r >= 4 && r <= 8);
      v   = ($urandom_range(0, 3) != 0);
      d   = mkword(HDR_VAL, tx);
      if (v) begin
        r2 = $urandom_range(0, 99);
        if (r2 < 6) begin
          d = mkword(HDR_VAL, tx + $urandom_range(1, SEQ_MOD - 1));
        end else if (r2 < 9) begin
          h = $urandom_range(0, 15);
          if (h == HDR_VAL) h = 11;
          d = mkword(h, tx);
        end else if (r2 < 10) begin
          tx = tx + 1;
          d = mkword(HDR_VAL, tx);
        end else if (r2 < 11) begin
          tx = tx - 1;
          d = mkword(HDR_VAL, tx);
        end
        tx++;
        if (tx < 0) tx = tx + SEQ_MOD;
      end
      cyc(rst, al, v, clr, d);
    end

    // Relock, then a reset mid-operation with busy inputs.
    for (int i = 0; i < 24; i++) good_word();
    cyc(1'b1, 1'b1, 1'b1, 1'b1, mkword(HDR_VAL, tx + 5));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, mkword(HDR_VAL, tx + 6));
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Every prediction must have been consumed by the monitor.
    @(posedge clk160);
    #3;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_tds_frame_checker

// File: doc/tds_frame_checker.md
Name: tds_frame_checker

Overview:
- Parametrised successor to the fixed strip/pad data checkers.
- Sits after a deserializer in the clk160 domain. Checks each valid word for a fixed header field and an incrementing sequence field.
- Locks using a hunt/sync/linked state machine and drops lock after repeated errors.
- Keeps saturating error and word statistics, readable over VIO/ILA.
- One instance per data stream; DATA_W, field layout and thresholds are all generic.

Parameters:
- DATA_W, 30, width of data_in.
- HDR_W, 4, header field width; the field is data_in[DATA_W-1 -: HDR_W].
- HDR_VAL, 4'hA, required header value.
- CNT_W, 10, sequence field width; the field is data_in[CNT_W-1:0]. Constraint: HDR_W+CNT_W <= DATA_W.
- SYNC_CNT, 16, consecutive good words needed to declare lock (1..1023).
- LOSS_THR, 4, consecutive bad words in LINKED that drop lock (1..255).
- ERR_W, 16, width of err_cnt.

Ports:
- clk160, in, 1, sole clock.
- reset_160M, in, 1, synchronous, active-high reset.
- data_in, in, DATA_W, word from the deserializer.
- data_valid, in, 1, data_in qualifier; sampled only when high.
- rx_aligned, in, 1, deserializer alignment status.
- clear_cnt, in, 1, synchronous clear of err_cnt and word_cnt.
- linked, out, 1, high while in LINKED.
- state, out, 2, 0=IDLE, 1=HUNT, 2=SYNC, 3=LINKED.
- syn_cnt, out, 10, current run of consecutive good words in SYNC.
- err_cnt, out, ERR_W, bad words counted in LINKED; saturating.
- word_cnt, out, 32, valid words received in LINKED; saturating.

Behaviour:
- Outputs are registered. Reset values: all outputs 0, state=IDLE, expected sequence=0, bad_run=0.
- Good word: header field == HDR_VAL AND sequence field == exp_seq.
- exp_seq update on every valid word:
  - HUNT: exp_seq <= seq+1.
  - SYNC/LINKED: exp_seq <= exp_seq+1 whether the word is good or bad.
  - So one corrupted word costs exactly one error, while a dropped or inserted word produces persistent errors.
- Sequence arithmetic is modulo 2^CNT_W; all-ones followed by 0 is good.
- IDLE: when rx_aligned=1, go to HUNT on the next edge.
- HUNT: a valid word with the correct header loads exp_seq, sets syn_cnt=1 and moves to SYNC. If SYNC_CNT==1, it moves directly to LINKED instead.
- SYNC:
  - Good word: syn_cnt+1. Reaching SYNC_CNT moves to LINKED, and linked=1 in the cycle after the sampling edge.
  - Bad word: move to HUNT with syn_cnt=0.
- LINKED:
  - Every valid word increments word_cnt.
  - Bad word: err_cnt+1 and bad_run+1. bad_run reaching LOSS_THR moves to HUNT with linked=0 next cycle.
  - Good word: bad_run=0.
  - syn_cnt holds SYNC_CNT while in LINKED.
- rx_aligned=0 in any state forces IDLE on the next edge, with linked=0, syn_cnt=0 and bad_run=0. This has priority over every data event.
- data_valid=0: no state, counter or exp_seq change.
- Counters: err_cnt and word_cnt saturate at all-ones. Link loss does not clear them.
- clear_cnt=1 zeroes both counters on the next edge. A coincident increment is discarded, so clear wins.
- reset_160M mid-operation returns everything to reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro TDS_FRAME_CHECKER_ERR_LOG_EN.
- Defined:
  - Adds outputs first_err_data (DATA_W), first_err_exp (CNT_W) and first_err_valid (1).
  - These latch on the first bad word in LINKED after reset or clear_cnt, then hold until the next reset or clear_cnt.
- Undefined: those ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package tds_check_pkg holds:
  - state encoding constants IDLE/HUNT/SYNC/LINKED;
  - the syn_cnt width constant (10);
  - the word_cnt width constant (32).
- One natural sub-module, sat_counter (generic WIDTH, with inc and clr inputs, clr wins). It is instantiated for err_cnt and word_cnt.

Test Plan:
- Clean lock: rx_aligned=1, header 4'hA, sequence 0,1,2,… every cycle → state 1→2, linked=1 one cycle after the 16th good word; err_cnt=0; word_cnt increments per word.
- Sequence wrap: lock, then feed 1022,1023,0,1 → no errors, linked stays 1.
- Single corruption: while linked, corrupt the sequence of one word (send 5 in place of 100), then resume 101 → err_cnt=1, linked stays 1, bad_run back to 0.
- Lock loss: while linked, drop one word → 4 consecutive errors, state=HUNT and linked=0 after the 4th; resumes locking; err_cnt keeps 4.
- Priority and saturation: ERR_W=4, force 20 errors → err_cnt=15. Assert clear_cnt in the same cycle as an error → 0. Drop rx_aligned mid-SYNC → IDLE, syn_cnt=0.
- Reset and log: with TDS_FRAME_CHECKER_ERR_LOG_EN, the first bad word 0x2A00_0123 is captured with first_err_exp equal to the expected sequence. A later reset_160M clears all outputs on the next edge.
